// File: rtl/register_bank_if.sv
// Write-port handshake, commit control and dual read ports of the register bank.
interface register_bank_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 wr_valid;
  logic                 wr_ready;
  logic [2:0]           wr_addr;
  logic [DATA_BITS-1:0] wr_data;
  logic                 commit_en;
  logic [2:0]           rd_addr_a;
  logic [DATA_BITS-1:0] rd_data_a;
  logic [2:0]           rd_addr_b;
  logic [DATA_BITS-1:0] rd_data_b;
  logic                 wb_busy;

  modport master (
    output wr_valid, wr_addr, wr_data, commit_en, rd_addr_a, rd_addr_b,
    input  wr_ready, rd_data_a, rd_data_b, wb_busy
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, commit_en, rd_addr_a, rd_addr_b,
    output wr_ready, rd_data_a, rd_data_b, wb_busy
  );
endinterface

// File: rtl/register_bank.sv
// 8-entry register file: two combinational read ports with bypass from a
// one-entry write-back slot that retires into the array when commit_en allows.
module register_bank #(
  parameter int unsigned DATA_BITS = 8,
  parameter bit          ZERO_R0   = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  register_bank_if.slave  bus
);
  localparam int unsigned DEPTH     = 8;
  localparam int unsigned ADDR_BITS = 3;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] data;
  } slot_t;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t               state;
  state_t               state_next;
  slot_t                slot;
  logic [DATA_BITS-1:0] mem [DEPTH];

  logic                 ready;
  logic                 busy;
  logic                 commit;
  logic                 capture;

  logic [ADDR_BITS-1:0] rd_addr [2];
  logic [DATA_BITS-1:0] rd_data [2];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  // Next state: a retiring slot is refilled in the same cycle if a write is offered
  always_comb begin
    state_next = state;
    unique case (state)
      EMPTY: if (bus.wr_valid) state_next = FULL;
      FULL:  if (bus.commit_en && !bus.wr_valid) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // Outputs: ready depends only on state and commit_en, never on wr_valid
  always_comb begin
    ready  = 1'b0;
    busy   = 1'b0;
    commit = 1'b0;
    unique case (state)
      EMPTY: ready = 1'b1;
      FULL: begin
        busy = 1'b1;
        if (bus.commit_en) begin
          ready  = 1'b1;
          commit = 1'b1;
        end
      end
      default: ready = 1'b0;
    endcase
  end

  assign capture      = bus.wr_valid & ready;
  assign bus.wr_ready = ready;
  assign bus.wb_busy  = busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        slot <= '0;
    else if (capture) slot <= '{addr: bus.wr_addr, data: bus.wr_data};
  end

  // Array only changes on a commit; r0 writes are dropped when r0 is hardwired
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (commit && !(ZERO_R0 && slot.addr == '0)) begin
      mem[slot.addr] <= slot.data;
    end
  end

  assign rd_addr[0] = bus.rd_addr_a;
  assign rd_addr[1] = bus.rd_addr_b;

  // Read mux per port: hardwired zero, then slot bypass, then array
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = mem[rd_addr[p]];
      if (ZERO_R0 && rd_addr[p] == '0)
        rd_data[p] = '0;
      else if (state == FULL && slot.addr == rd_addr[p])
        rd_data[p] = slot.data;
    end
  end

  assign bus.rd_data_a = rd_data[0];
  assign bus.rd_data_b = rd_data[1];
endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank: expectations are queued as stimulus is
// driven and compared against the DUT outputs mid-cycle.
module tb_register_bank;
  localparam int SIG_RDA  = 0;
  localparam int SIG_RDB  = 1;
  localparam int SIG_RDY  = 2;
  localparam int SIG_BUSY = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  register_bank_if #(.DATA_BITS(8)) bus0 ();
  register_bank_if #(.DATA_BITS(8)) bus1 ();

  register_bank #(.DATA_BITS(8), .ZERO_R0(1'b0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  register_bank #(.DATA_BITS(8), .ZERO_R0(1'b1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

  typedef struct {
    string      tag;
    int         dut;
    int         sig;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] observe(input int dut, input int sig);
    logic [7:0] v;
    v = 8'hxx;
    if (dut == 0) begin
      case (sig)
        SIG_RDA:  v = bus0.rd_data_a;
        SIG_RDB:  v = bus0.rd_data_b;
        SIG_RDY:  v = {7'd0, bus0.wr_ready};
        default:  v = {7'd0, bus0.wb_busy};
      endcase
    end else begin
      case (sig)
        SIG_RDA:  v = bus1.rd_data_a;
        SIG_RDB:  v = bus1.rd_data_b;
        SIG_RDY:  v = {7'd0, bus1.wr_ready};
        default:  v = {7'd0, bus1.wb_busy};
      endcase
    end
    return v;
  endfunction

  task automatic expect_sig(input string tag, input int dut, input int sig, input logic [7:0] exp);
    sb.push_back('{tag, dut, sig, exp});
  endtask

  // Drives a read address and queues the value that port must show
  task automatic expect_rd(input string tag, input int dut, input int port,
                           input logic [2:0] addr, input logic [7:0] exp);
    if (dut == 0) begin
      if (port == 0) bus0.rd_addr_a = addr; else bus0.rd_addr_b = addr;
    end else begin
      if (port == 0) bus1.rd_addr_a = addr; else bus1.rd_addr_b = addr;
    end
    sb.push_back('{tag, dut, (port == 0) ? SIG_RDA : SIG_RDB, exp});
  endtask

  task automatic drive_wr(input int dut, input logic valid, input logic [2:0] addr,
                          input logic [7:0] data, input logic commit);
    if (dut == 0) begin
      bus0.wr_valid = valid; bus0.wr_addr = addr; bus0.wr_data = data; bus0.commit_en = commit;
    end else begin
      bus1.wr_valid = valid; bus1.wr_addr = addr; bus1.wr_data = data; bus1.commit_en = commit;
    end
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.dut, e.sig), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_wr(0, 1'b0, 3'd0, 8'h00, 1'b0);
    drive_wr(1, 1'b0, 3'd0, 8'h00, 1'b0);
    bus0.rd_addr_a = 3'd0; bus0.rd_addr_b = 3'd0;
    bus1.rd_addr_a = 3'd0; bus1.rd_addr_b = 3'd0;

    // 1: reset state
    #2;
    expect_sig("rst_busy", 0, SIG_BUSY, 8'd0);
    expect_sig("rst_ready", 0, SIG_RDY, 8'd1);
    drain();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      expect_rd("t1_a0", 0, 0, 3'(i), 8'h00);
      expect_rd("t1_b0", 0, 1, 3'(7 - i), 8'h00);
      expect_rd("t1_a1", 1, 0, 3'(i), 8'h00);
      expect_rd("t1_b1", 1, 1, 3'(7 - i), 8'h00);
      settle();
    end

    // 2: write r3=A5 with commit enabled
    tick();
    drive_wr(0, 1'b1, 3'd3, 8'hA5, 1'b1);
    expect_sig("t2_ready", 0, SIG_RDY, 8'd1);
    settle();
    tick();
    drive_wr(0, 1'b0, 3'd0, 8'h00, 1'b1);
    expect_rd("t2_bypass", 0, 0, 3'd3, 8'hA5);
    expect_sig("t2_busy1", 0, SIG_BUSY, 8'd1);
    settle();
    tick();
    expect_sig("t2_busy0", 0, SIG_BUSY, 8'd0);
    expect_rd("t2_array", 0, 0, 3'd3, 8'hA5);
    settle();

    // 3: stalled commit holds off the next write
    tick();
    drive_wr(0, 1'b1, 3'd5, 8'h3C, 1'b0);
    expect_sig("t3_ready_empty", 0, SIG_RDY, 8'd1);
    settle();
    tick();
    drive_wr(0, 1'b1, 3'd6, 8'h11, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      expect_sig("t3_ready0", 0, SIG_RDY, 8'd0);
      expect_sig("t3_busy", 0, SIG_BUSY, 8'd1);
      expect_rd("t3_r5_bypass", 0, 0, 3'd5, 8'h3C);
      expect_rd("t3_r6_stall", 0, 1, 3'd6, 8'h00);
      settle();
    end
    tick();
    drive_wr(0, 1'b1, 3'd6, 8'h11, 1'b1);
    expect_sig("t3_ready_commit", 0, SIG_RDY, 8'd1);
    settle();
    tick();
    drive_wr(0, 1'b0, 3'd0, 8'h00, 1'b0);
    expect_rd("t3_r5_array", 0, 0, 3'd5, 8'h3C);
    expect_rd("t3_r6_bypass", 0, 1, 3'd6, 8'h11);
    expect_sig("t3_busy_r6", 0, SIG_BUSY, 8'd1);
    settle();
    tick();
    drive_wr(0, 1'b0, 3'd0, 8'h00, 1'b1);
    settle();
    tick();
    expect_sig("t3_busy0", 0, SIG_BUSY, 8'd0);
    expect_rd("t3_r6_array", 0, 1, 3'd6, 8'h11);
    settle();

    // 4: streaming writes to r1
    tick();
    drive_wr(0, 1'b1, 3'd1, 8'h01, 1'b1);
    settle();
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (i < 3) drive_wr(0, 1'b1, 3'd1, 8'(i + 1), 1'b1);
      else       drive_wr(0, 1'b0, 3'd0, 8'h00, 1'b1);
      expect_rd("t4_stream", 0, 0, 3'd1, 8'(i));
      expect_sig("t4_ready", 0, SIG_RDY, 8'd1);
      settle();
    end
    tick();
    expect_rd("t4_final", 0, 0, 3'd1, 8'h03);
    expect_sig("t4_busy0", 0, SIG_BUSY, 8'd0);
    settle();

    // 5: r0 writes, hardwired zero on dut1 only
    tick();
    drive_wr(0, 1'b1, 3'd0, 8'h5A, 1'b1);
    drive_wr(1, 1'b1, 3'd0, 8'hFF, 1'b1);
    expect_sig("t5_ready1", 1, SIG_RDY, 8'd1);
    expect_rd("t5_z_pre", 1, 0, 3'd0, 8'h00);
    settle();
    tick();
    drive_wr(0, 1'b0, 3'd0, 8'h00, 1'b1);
    drive_wr(1, 1'b0, 3'd0, 8'h00, 1'b1);
    expect_sig("t5_busy1", 1, SIG_BUSY, 8'd1);
    expect_rd("t5_z_slot", 1, 0, 3'd0, 8'h00);
    expect_rd("t5_r0_bypass", 0, 0, 3'd0, 8'h5A);
    settle();
    tick();
    expect_sig("t5_busy1_0", 1, SIG_BUSY, 8'd0);
    expect_rd("t5_z_post", 1, 0, 3'd0, 8'h00);
    expect_rd("t5_r0_array", 0, 0, 3'd0, 8'h5A);
    settle();

    // 6: async reset discards a pending write
    tick();
    drive_wr(0, 1'b1, 3'd7, 8'h77, 1'b0);
    settle();
    tick();
    drive_wr(0, 1'b0, 3'd0, 8'h00, 1'b0);
    expect_rd("t6_r7_bypass", 0, 0, 3'd7, 8'h77);
    expect_sig("t6_busy1", 0, SIG_BUSY, 8'd1);
    settle();
    #2 reset = 1'b1;
    #1;
    expect_rd("t6_r7_rst", 0, 0, 3'd7, 8'h00);
    expect_rd("t6_r3_rst", 0, 1, 3'd3, 8'h00);
    expect_sig("t6_busy_rst", 0, SIG_BUSY, 8'd0);
    expect_sig("t6_ready_rst", 0, SIG_RDY, 8'd1);
    drain();
    tick();
    reset = 1'b0;
    tick();
    expect_rd("t6_r7_after", 0, 0, 3'd7, 8'h00);
    expect_rd("t6_r1_after", 0, 1, 3'd1, 8'h00);
    settle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
